counter_scan_ctrl: RTL and testbench

Run/stop/step controller and display scanner for the 4-bit mod-13 counter datapath. It converts three pushbutton levels into single-cycle count enables and a clear strobe, paces automatic counting with a prescaler, and time-multiplexes the counter value as two decimal digits onto the shared `num1` 7-segment bus. It sits between the board buttons and the counter/display pins, and the counter itself stays a separate datapath.

---
 rtl/counter_scan_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 30 +++
 rtl/counter_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_counter_scan_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scan_pkg.sv
// Shared definitions for the run/stop/step controller and display scanner.
// Holds the controller state encoding, the active-low digit-select codes,
// the 7-segment patterns ({DP,a..g}, active-high) and the decoder codes
// used for blank and "E".
package counter_scan_pkg;

    typedef enum logic [1:0] {
        ST_CLR   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Active-low digit select on the shared num1 bus.
    typedef enum logic [1:0] {
        SEL_TENS  = 2'b01,
        SEL_UNITS = 2'b10,
        SEL_OFF   = 2'b11
    } scan_sel_t;

    // Bit positions of the buttons inside the packed button vectors.
    localparam int unsigned BTN_STEP  = 0;
    localparam int unsigned BTN_START = 1;
    localparam int unsigned BTN_STOP  = 2;

    // Decoder input codes beyond the decimal digits.
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h30;
    localparam logic [7:0] SEG_2     = 8'h6D;
    localparam logic [7:0] SEG_3     = 8'h79;
    localparam logic [7:0] SEG_4     = 8'h33;
    localparam logic [7:0] SEG_5     = 8'h5B;
    localparam logic [7:0] SEG_6     = 8'h5F;
    localparam logic [7:0] SEG_7     = 8'h70;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h7B;
    localparam logic [7:0] SEG_E     = 8'b0100_1111;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder.
//   code : 4-bit digit code, 0..9 are decimal digits, CODE_E shows "E",
//          every other code blanks the digit
//   seg  : {DP,a..g}, active-high
module seg7_decode
    import counter_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            CODE_E:  seg = SEG_E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter_scan_ctrl.sv
// Run/stop/step controller and two-digit display scanner for the mod-13
// counter datapath. Everything runs on the rising edge of button_clk with a
// synchronous active-low reset.
//   button_clk        : system clock
//   sw6_reset_n       : synchronous reset, active-low
//   btn_start/stop/step : raw asynchronous pushbutton levels
//   cnt_state         : current counter value
//   cnt_en            : one-cycle count-enable pulse
//   cnt_clr           : one-cycle counter clear pulse
//   run_led           : high while running (one cycle behind the FSM)
//   led8_C            : high while cnt_state == TERMINAL (one cycle behind)
//   num1_scan_select  : active-low digit select, 11 off / 10 units / 01 tens
//   num1_seg7         : {DP,a..g} for the selected digit, active-high
module counter_scan_ctrl
    import counter_scan_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int SCAN_DIV  = 2,
    parameter int TERMINAL  = 12,
    parameter int AUTO_WRAP = 1
) (
    input  logic       button_clk,
    input  logic       sw6_reset_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_step,
    input  logic [3:0] cnt_state,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       run_led,
    output logic       led8_C,
    output logic [1:0] num1_scan_select,
    output logic [7:0] num1_seg7
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    TERM       = 4'(TERMINAL);

    // ---------------- button synchronisers and edge detect ----------------
    logic [2:0] btn_raw;
    logic [2:0] sync1, sync2, sync_prev;
    logic [2:0] armed;
    logic [2:0] btn_ev;
    logic [1:0] sync_vld;

    assign btn_raw = {btn_stop, btn_start, btn_step};

    // sync_vld[1] marks that sync2 carries a real post-reset sample. A button
    // only arms once a real low level has been seen, so a button held through
    // reset produces no event until it is released and pressed again.
    always_ff @(posedge button_clk) begin
        if (!sw6_reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            armed     <= '0;
            btn_ev    <= '0;
            sync_vld  <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            sync_prev <= sync2;
            sync_vld  <= {sync_vld[0], 1'b1};
            if (sync_vld[1]) begin
                armed <= armed | ~sync2;
            end
            btn_ev    <= sync2 & ~sync_prev & armed;
        end
    end

    logic ev_start, ev_stop, ev_step;
    assign ev_start = btn_ev[BTN_START];
    assign ev_stop  = btn_ev[BTN_STOP];
    assign ev_step  = btn_ev[BTN_STEP];

    // ---------------- controller FSM and prescaler ----------------
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          en_d, clr_d;
    logic          at_term;

    assign at_term = (cnt_state == TERM);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            ST_CLR: begin
                clr_d   = 1'b1;
                presc_d = '0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_step) begin
                    en_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop wins over the prescaler wrap: the prescaler freezes
                // and no pulse is issued in that cycle.
                if (ev_stop) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if ((AUTO_WRAP == 0) && at_term) begin
                        state_d = ST_PAUSE;
                    end else begin
                        en_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ev_stop) begin
                    state_d = ST_CLR;
                end else if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_step) begin
                    en_d = 1'b1;
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    always_ff @(posedge button_clk) begin
        if (!sw6_reset_n) begin
            state_q <= ST_CLR;
            presc_q <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            run_led <= 1'b0;
            led8_C  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_en  <= en_d;
            cnt_clr <= clr_d;
            run_led <= (state_q == ST_RUN);
            led8_C  <= at_term;
        end
    end

    // ---------------- display scanner ----------------
    logic [SW-1:0] scan_cnt;
    logic          show_tens;
    logic [3:0]    digit_code;
    logic [7:0]    seg_d;
    scan_sel_t     sel_q;

    always_comb begin
        digit_code = CODE_BLANK;
        if (cnt_state > TERM) begin
            digit_code = show_tens ? CODE_BLANK : CODE_E;
        end else if (cnt_state >= 4'd10) begin
            digit_code = show_tens ? 4'd1 : (cnt_state - 4'd10);
        end else begin
            digit_code = show_tens ? CODE_BLANK : cnt_state;
        end
    end

    seg7_decode u_seg7_decode (
        .code (digit_code),
        .seg  (seg_d)
    );

    // Segments and select are registered together from the same digit slot.
    always_ff @(posedge button_clk) begin
        if (!sw6_reset_n) begin
            scan_cnt  <= '0;
            show_tens <= 1'b0;
            sel_q     <= SEL_OFF;
            num1_seg7 <= SEG_BLANK;
        end else begin
            sel_q     <= show_tens ? SEL_TENS : SEL_UNITS;
            num1_seg7 <= seg_d;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                show_tens <= ~show_tens;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end
        end
    end

    assign num1_scan_select = sel_q;

endmodule

// File: tb/tb_counter_scan_ctrl.sv
// Scoreboard bench for counter_scan_ctrl. Two instances share buttons and
// reset: unit 0 with AUTO_WRAP=1, unit 1 with AUTO_WRAP=0. Each has its own
// mod-13 counter driven by its pulses. A reference model predicts pulses
// (pushed into per-unit queues) and status/display values; a monitor on the
// falling edge pops and compares.
module tb_counter_scan_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int TERM     = 12;

    localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3;
    localparam int K_EN = 0, K_CLR = 1;
    localparam int I_STEP = 0, I_START = 1, I_STOP = 2;

    typedef struct {
        int cyc;
        int kind;
    } pulse_t;

    typedef struct {
        int       due;
        bit [2:0] ev;
    } pend_t;

    logic       clk;
    logic       rst_n;
    logic       b_start, b_stop, b_step;
    logic [3:0] cs [2];
    logic       en [2];
    logic       clr [2];
    logic       rl [2];
    logic       l8 [2];
    logic [1:0] sel [2];
    logic [7:0] seg [2];

    logic       ovr;
    logic [3:0] ovr_val;
    int         cnt_v [2];

    int n_chk, n_fail;

    counter_scan_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .TERMINAL (TERM),
        .AUTO_WRAP(1)
    ) dut_wrap (
        .button_clk      (clk),
        .sw6_reset_n     (rst_n),
        .btn_start       (b_start),
        .btn_stop        (b_stop),
        .btn_step        (b_step),
        .cnt_state       (cs[0]),
        .cnt_en          (en[0]),
        .cnt_clr         (clr[0]),
        .run_led         (rl[0]),
        .led8_C          (l8[0]),
        .num1_scan_select(sel[0]),
        .num1_seg7       (seg[0])
    );

    counter_scan_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .TERMINAL (TERM),
        .AUTO_WRAP(0)
    ) dut_stop (
        .button_clk      (clk),
        .sw6_reset_n     (rst_n),
        .btn_start       (b_start),
        .btn_stop        (b_stop),
        .btn_step        (b_step),
        .cnt_state       (cs[1]),
        .cnt_en          (en[1]),
        .cnt_clr         (clr[1]),
        .run_led         (rl[1]),
        .led8_C          (l8[1]),
        .num1_scan_select(sel[1]),
        .num1_seg7       (seg[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath environment: mod-13, reacts to the DUT pulses.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n || clr[u]) cnt_v[u] <= 0;
            else if (en[u]) cnt_v[u] <= (cnt_v[u] >= TERM) ? 0 : cnt_v[u] + 1;
        end
    end

    assign cs[0] = ovr ? ovr_val : cnt_v[0][3:0];
    assign cs[1] = ovr ? ovr_val : cnt_v[1][3:0];

    // ---------------- reference model ----------------
    logic [7:0] seg_tab [10];
    initial seg_tab = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                        8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};

    bit       aw_of [2];
    initial aw_of = '{1'b1, 1'b0};

    int       cyc;
    int       since;
    int       mode [2];
    int       run_acc [2];
    bit [2:0] last_s, armed_s, s, ev, newev;
    pend_t    pend [$];
    pend_t    ptmp;
    pulse_t   sbq [2][$];
    pulse_t   qtmp;

    bit         e_run [2];
    bit         e_l8 [2];
    logic [1:0] e_sel;
    logic [7:0] e_seg [2];

    function automatic logic [7:0] disp(input int v, input bit tens);
        if (v > TERM) return tens ? 8'h00 : 8'h4F;
        if (tens) return (v >= 10) ? seg_tab[1] : 8'h00;
        return seg_tab[v % 10];
    endfunction

    task automatic expect_pulse(input int u, input int kind);
        qtmp.cyc  = cyc;
        qtmp.kind = kind;
        sbq[u].push_back(qtmp);
    endtask

    task automatic unit_step(input int u, input bit [2:0] e);
        case (mode[u])
            M_CLR: begin
                expect_pulse(u, K_CLR);
                run_acc[u] = 0;
                mode[u] = M_IDLE;
            end
            M_IDLE: begin
                if (e[I_START]) mode[u] = M_RUN;
                else if (e[I_STEP]) expect_pulse(u, K_EN);
            end
            M_RUN: begin
                if (e[I_STOP]) mode[u] = M_PAUSE;
                else begin
                    run_acc[u]++;
                    if (run_acc[u] % TICK_DIV == 0) begin
                        if (!aw_of[u] && int'(cs[u]) == TERM) mode[u] = M_PAUSE;
                        else expect_pulse(u, K_EN);
                    end
                end
            end
            default: begin
                if (e[I_STOP]) mode[u] = M_CLR;
                else if (e[I_START]) mode[u] = M_RUN;
                else if (e[I_STEP]) expect_pulse(u, K_EN);
            end
        endcase
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            last_s  = '0;
            armed_s = '0;
            since   = 0;
            e_sel   = 2'b11;
            for (int u = 0; u < 2; u++) begin
                mode[u]    = M_CLR;
                run_acc[u] = 0;
                e_run[u]   = 1'b0;
                e_l8[u]    = 1'b0;
                e_seg[u]   = 8'h00;
            end
        end else begin
            since++;
            ev = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ptmp = pend.pop_front();
                ev = ptmp.ev;
            end
            e_sel = (((since - 1) / SCAN_DIV) % 2 == 1) ? 2'b01 : 2'b10;
            for (int u = 0; u < 2; u++) begin
                e_run[u] = (mode[u] == M_RUN);
                e_l8[u]  = (int'(cs[u]) == TERM);
                e_seg[u] = disp(int'(cs[u]), e_sel == 2'b01);
                unit_step(u, ev);
            end
            // Button sampled now takes effect three edges later.
            s = {b_stop, b_start, b_step};
            newev = s & ~last_s & armed_s;
            armed_s = armed_s | ~s;
            last_s = s;
            if (newev != 3'b000) begin
                ptmp.due = cyc + 3;
                ptmp.ev  = newev;
                pend.push_back(ptmp);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int u, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s unit%0d edge %0d: got %0h expected %0h", name, u, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int u = 0; u < 2; u++) begin
                while (sbq[u].size() > 0 && sbq[u][0].cyc < cyc) begin
                    qtmp = sbq[u].pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL pulse_missing unit%0d: got none, expected %s at edge %0d",
                             u, (qtmp.kind == K_CLR) ? "cnt_clr" : "cnt_en", qtmp.cyc);
                end
                if (en[u] || clr[u]) begin
                    n_chk++;
                    if (en[u] && clr[u]) begin
                        n_fail++;
                        $display("FAIL pulse_overlap unit%0d edge %0d: got en=1 clr=1, expected at most one", u, cyc);
                    end else if (sbq[u].size() > 0 && sbq[u][0].cyc == cyc &&
                                 sbq[u][0].kind == (clr[u] ? K_CLR : K_EN)) begin
                        qtmp = sbq[u].pop_front();
                    end else begin
                        n_fail++;
                        $display("FAIL pulse_unexpected unit%0d edge %0d: got en=%0b clr=%0b, expected none",
                                 u, cyc, en[u], clr[u]);
                    end
                end
                chk("run_led", u, int'(rl[u]), int'(e_run[u]));
                chk("led8_C", u, int'(l8[u]), int'(e_l8[u]));
                chk("scan_select", u, int'(sel[u]), int'(e_sel));
                chk("seg7", u, int'(seg[u]), int'(e_seg[u]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input bit [2:0] m, input int hold, input int gap);
        {b_stop, b_start, b_step} = m;
        repeat (hold) @(negedge clk);
        {b_stop, b_start, b_step} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    int r;
    int hold;
    bit [2:0] m;

    initial begin
        rst_n = 1'b0;
        b_start = 1'b0;
        b_stop = 1'b0;
        b_step = 1'b0;
        ovr = 1'b0;
        ovr_val = 4'd0;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;

        // Reset held for three edges, then release.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Three single steps from IDLE.
        for (int i = 0; i < 3; i++) press(3'b001, 5, 5);

        // RUN long enough for both units to pass/stop at 12.
        press(3'b010, 1, 60);

        // Start and stop together in RUN, then held stop, then run/stop/stop.
        press(3'b110, 2, 6);
        press(3'b100, 20, 6);
        press(3'b010, 2, 10);
        press(3'b100, 2, 6);
        press(3'b100, 2, 8);

        // Out-of-range value on the counter input.
        ovr = 1'b1;
        ovr_val = 4'd14;
        repeat (8) @(negedge clk);
        ovr = 1'b0;

        // Start held through a reset gives no event; a fresh press does.
        press(3'b010, 2, 8);
        b_start = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        b_start = 1'b0;
        repeat (5) @(negedge clk);
        press(3'b010, 2, 20);

        // Randomised button traffic with occasional resets and overrides.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            ovr = ($urandom_range(0, 9) == 0);
            ovr_val = 4'($urandom_range(0, 15));
            if (r < 60) m = 3'b001 << $urandom_range(0, 2);
            else m = 3'($urandom_range(1, 7));
            hold = $urandom_range(1, 6);
            press(m, hold, $urandom_range(0, 12));
            ovr = 1'b0;
        end

        repeat (12) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_chk++;
            if (sbq[u].size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain unit%0d: got %0d pending pulses, expected 0", u, sbq[u].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
